ysyx_bus_rr_arbiter: RTL
========================

YSYX_BUS_RR_ARBITER -- requirements
Module: ysyx_bus_rr_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 32, address width.
- NR, 2, number of read clients (2..8).
- TO_CYC, 1024, watchdog limit in cycles.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; ports, clock and reset first:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rd_valid  in  NR  per-client read request.
- rd_addr  in  NR*ADDR_W  per-client address; client i is slice i.
- rd_size  in  NR*3  per-client AXI size code.
- rd_grant  out  NR  one-hot, one-cycle acceptance pulse.
- rd_rvalid  out  NR  one-hot, one-cycle response pulse.
- rd_rdata  out  32  response data, shared by all clients.
- rd_err  out  1  response error, qualified by rd_rvalid.
- wr_valid  in  1  store request.
- wr_addr  in  ADDR_W  store address.
- wr_data  in  32  store data.
- wr_strb  in  4  store byte strobes.
- wr_ready  out  1  store accepted.
- wr_done  out  1  store completion pulse.
- wr_err  out  1  store error, qualified by wr_done.
- io_master_ar{valid,addr,size,id}  out  1/ADDR_W/3/4  AXI4 read address channel.
- io_master_arready  in  1  AXI4 read address ready.
- io_master_r{valid,data,resp,last}  in  1/64/2/1  AXI4 read data channel.
- io_master_rready  out  1  AXI4 read data ready.
- io_master_aw{valid,addr,size}  out  1/ADDR_W/3  AXI4 write address channel.
- io_master_awready  in  1  AXI4 write address ready.
- io_master_w{valid,data,strb,last}  out  1/64/8/1  AXI4 write data channel.
- io_master_wready  in  1  AXI4 write data ready.
- io_master_b{valid,resp}  in  1/2  AXI4 write response channel.
- io_master_bready  out  1  AXI4 write response ready.
- watchdog_err  out  1  sticky timeout flag.
- arlen=awlen=0 and burst=INCR SHALL be constant.

Function
REQ-003 The read FSM SHALL have states R_IDLE, R_AR, R_DATA, with one read outstanding at a time.
REQ-004 In R_IDLE with any rd_valid set, the arbiter SHALL grant the first requesting client searching upward from ptr+1 (mod NR).
- On grant: pulse rd_grant[i] in that cycle; latch addr, size and id=i; enter R_AR.
REQ-005 In R_AR, arvalid SHALL be 1 with the latched addr/size/id held stable until arready is sampled 1; then the FSM SHALL enter R_DATA.
REQ-006 rready SHALL be 1 only in R_DATA.
- On rvalid&rlast: pulse rd_rvalid[i] for one cycle.
- rd_rdata = rdata[63:32] if latched addr[2]=1, else rdata[31:0].
- rd_err = (rresp!=0).
- Set ptr=i; return to R_IDLE.
REQ-007 Grant-to-arvalid latency SHALL be 1 cycle; a new grant SHALL occur no earlier than the cycle after rd_rvalid.
REQ-008 A client that holds rd_valid SHALL be granted within NR transactions (no starvation).
REQ-009 The write FSM SHALL have states W_IDLE, W_ADDR, W_RESP, independent of the read FSM.
REQ-010 On wr_valid in W_IDLE, the block SHALL pulse wr_ready, latch the request, and enter W_ADDR.
- awvalid and wvalid SHALL rise together.
- Each SHALL drop independently on its own handshake, including when both handshakes fall in the same cycle.
- W_RESP SHALL be entered once both handshakes have completed.
REQ-011 Write data formatting:
- wdata = {wr_data, wr_data}.
- wstrb = wr_strb << latched addr[2:0] (8-bit, truncated).
- wlast = wvalid.
- awsize from strb: 1→0, 3→1, F→2, other→2.
REQ-012 In W_RESP, bready SHALL be 1; on bvalid, pulse wr_done with wr_err=(bresp!=0) and return to W_IDLE.
REQ-013 rvalid outside R_DATA and bvalid outside W_RESP SHALL be ignored.

Reset
REQ-014 Asserting rst SHALL asynchronously force:
- both FSMs to IDLE;
- ptr=NR-1, so client 0 wins first;
- the watchdog counter to 0;
- every output to 0, except rready, bready, wlast and constant fields, which follow their state rules above.
REQ-015 Reset mid-transaction SHALL abort it silently: no rd_rvalid or wr_done pulse follows.

Configuration
REQ-016 With YSYX_ARB_WATCHDOG_EN defined, the watchdog SHALL operate as follows:
- A counter increments each cycle while the read FSM is not in R_IDLE, and clears on return to R_IDLE.
- On reaching TO_CYC, the read FSM returns to R_IDLE, rd_rvalid[i] pulses with rd_err=1, and watchdog_err sets (sticky until rst).
- The write path has the same behaviour on its own counter, with wr_done/wr_err.
REQ-017 Without YSYX_ARB_WATCHDOG_EN, no counters SHALL exist and watchdog_err SHALL be constant 0.

Verification
REQ-018 NR=2; both clients request continuously; arready/rvalid immediate -> grants alternate 0,1,0,1; arid matches the granted client.
REQ-019 Client 1 reads addr 0x80000004; rdata=0x11112222_33334444 -> rd_rdata=0x11112222, rd_err=0.
REQ-020 Store addr 0x80000006, strb 0x3, data 0xABCD; awready delayed 3 cycles, wready immediate -> wstrb=0xC0, awsize=1, exactly one wr_done after bvalid.
REQ-021 Read and write issued in the same cycle with overlapping handshakes -> both complete; no stray pulses.
REQ-022 YSYX_ARB_WATCHDOG_EN, TO_CYC=16, rvalid never asserted -> rd_rvalid with rd_err=1 after 16 cycles in R_AR/R_DATA; watchdog_err=1 until rst.
REQ-023 rst asserted while in R_DATA, then rvalid pulsed -> no rd_rvalid; all outputs at reset values.

Source files
------------

// File: rtl/ysyx_bus_rr_arbiter.sv
// Round-robin arbiter: NR read clients and one store port onto a single AXI4 master.
// Define YSYX_ARB_WATCHDOG_EN to build in the per-FSM timeout watchdog.
module ysyx_bus_rr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int NR     = 2,
    parameter int TO_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NR-1:0]        rd_valid,
    input  logic [NR*ADDR_W-1:0] rd_addr,
    input  logic [NR*3-1:0]      rd_size,
    output logic [NR-1:0]        rd_grant,
    output logic [NR-1:0]        rd_rvalid,
    output logic [31:0]          rd_rdata,
    output logic                 rd_err,
    input  logic                 wr_valid,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [31:0]          wr_data,
    input  logic [3:0]           wr_strb,
    output logic                 wr_ready,
    output logic                 wr_done,
    output logic                 wr_err,
    output logic                 io_master_arvalid,
    output logic [ADDR_W-1:0]    io_master_araddr,
    output logic [2:0]           io_master_arsize,
    output logic [3:0]           io_master_arid,
    output logic [7:0]           io_master_arlen,
    output logic [1:0]           io_master_arburst,
    input  logic                 io_master_arready,
    input  logic                 io_master_rvalid,
    input  logic [63:0]          io_master_rdata,
    input  logic [1:0]           io_master_rresp,
    input  logic                 io_master_rlast,
    output logic                 io_master_rready,
    output logic                 io_master_awvalid,
    output logic [ADDR_W-1:0]    io_master_awaddr,
    output logic [2:0]           io_master_awsize,
    output logic [7:0]           io_master_awlen,
    output logic [1:0]           io_master_awburst,
    input  logic                 io_master_awready,
    output logic                 io_master_wvalid,
    output logic [63:0]          io_master_wdata,
    output logic [7:0]           io_master_wstrb,
    output logic                 io_master_wlast,
    input  logic                 io_master_wready,
    input  logic                 io_master_bvalid,
    input  logic [1:0]           io_master_bresp,
    output logic                 io_master_bready,
    output logic                 watchdog_err
);

    localparam int PW = (NR > 1) ? $clog2(NR) : 1;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;

    rstate_t r_state, r_next;
    wstate_t w_state, w_next;

    logic [PW-1:0]     ptr, cur, sel, cand;
    logic              found;
    logic [ADDR_W-1:0] sel_addr, ar_addr;
    logic [2:0]        sel_size, ar_size;
    logic              r_fire, rd_finish, rd_timeout;

    logic              accept, aw_pend, w_pend, aw_fire, w_fire, b_fire;
    logic              wr_finish, wr_timeout;
    logic [ADDR_W-1:0] aw_addr;
    logic [2:0]        aw_size, strb_size;
    logic [63:0]       w_data;
    logic [7:0]        w_strb;

    // Rotating search starting just above the last served client.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        cand     = ptr;
        sel_addr = '0;
        sel_size = '0;
        for (int k = 0; k < NR; k++) begin
            cand = (cand == PW'(NR - 1)) ? '0 : cand + 1'b1;
            if (!found && rd_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (sel == PW'(i)) begin
                sel_addr = rd_addr[i*ADDR_W +: ADDR_W];
                sel_size = rd_size[i*3 +: 3];
            end
        end
    end

    assign r_fire    = (r_state == R_DATA) && io_master_rvalid && io_master_rlast;
    assign rd_finish = r_fire || rd_timeout;

    always_comb begin
        r_next    = r_state;
        rd_grant  = '0;
        rd_rvalid = '0;
        for (int i = 0; i < NR; i++) begin
            rd_grant[i]  = !rst && (r_state == R_IDLE) && found && (sel == PW'(i));
            rd_rvalid[i] = rd_finish && (cur == PW'(i));
        end
        case (r_state)
            R_IDLE:  if (found) r_next = R_AR;
            R_AR:    if (io_master_arready) r_next = R_DATA;
            R_DATA:  if (io_master_rvalid && io_master_rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
        if (rd_timeout) r_next = R_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            ptr     <= PW'(NR - 1);
            cur     <= '0;
            ar_addr <= '0;
            ar_size <= '0;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && found) begin
                cur     <= sel;
                ar_addr <= sel_addr;
                ar_size <= sel_size;
            end
            if (rd_finish) ptr <= cur;
        end
    end

    // A real response takes precedence over a coincident timeout.
    assign rd_rdata = r_fire ? (ar_addr[2] ? io_master_rdata[63:32] : io_master_rdata[31:0]) : 32'h0;
    assign rd_err   = r_fire ? (io_master_rresp != 2'b00) : rd_timeout;

    assign io_master_arvalid = (r_state == R_AR);
    assign io_master_araddr  = ar_addr;
    assign io_master_arsize  = ar_size;
    assign io_master_arid    = 4'(cur);
    assign io_master_arlen   = 8'h00;
    assign io_master_arburst = 2'b01;
    assign io_master_rready  = (r_state == R_DATA);

    assign accept  = !rst && (w_state == W_IDLE) && wr_valid;
    assign aw_fire = aw_pend && io_master_awready;
    assign w_fire  = w_pend && io_master_wready;
    assign b_fire  = (w_state == W_RESP) && io_master_bvalid;
    assign wr_finish = b_fire || wr_timeout;

    always_comb begin
        case (wr_strb)
            4'h1:    strb_size = 3'd0;
            4'h3:    strb_size = 3'd1;
            default: strb_size = 3'd2;
        endcase
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (accept) w_next = W_ADDR;
            W_ADDR:  if ((!aw_pend || aw_fire) && (!w_pend || w_fire)) w_next = W_RESP;
            W_RESP:  if (io_master_bvalid) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
        if (wr_timeout) w_next = W_IDLE;
    end

    // AW and W launch together but retire on their own handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            aw_addr <= '0;
            aw_size <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            w_state <= w_next;
            if (accept) begin
                aw_pend <= 1'b1;
                w_pend  <= 1'b1;
                aw_addr <= wr_addr;
                aw_size <= strb_size;
                w_data  <= {wr_data, wr_data};
                w_strb  <= 8'({4'b0000, wr_strb} << wr_addr[2:0]);
            end else if (wr_timeout) begin
                aw_pend <= 1'b0;
                w_pend  <= 1'b0;
            end else begin
                if (aw_fire) aw_pend <= 1'b0;
                if (w_fire) w_pend <= 1'b0;
            end
        end
    end

    assign wr_ready = accept;
    assign wr_done  = wr_finish;
    assign wr_err   = b_fire ? (io_master_bresp != 2'b00) : wr_timeout;

    assign io_master_awvalid = aw_pend;
    assign io_master_awaddr  = aw_addr;
    assign io_master_awsize  = aw_size;
    assign io_master_awlen   = 8'h00;
    assign io_master_awburst = 2'b01;
    assign io_master_wvalid  = w_pend;
    assign io_master_wdata   = w_data;
    assign io_master_wstrb   = w_strb;
    assign io_master_wlast   = w_pend;
    assign io_master_bready  = (w_state == W_RESP);

`ifdef YSYX_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TO_CYC + 1);

    logic [CW-1:0] rd_cnt, wr_cnt;
    logic          wd_flag;

    assign rd_timeout   = (r_state != R_IDLE) && (rd_cnt == CW'(TO_CYC - 1));
    assign wr_timeout   = (w_state != W_IDLE) && (wr_cnt == CW'(TO_CYC - 1));
    assign watchdog_err = wd_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            wd_flag <= 1'b0;
        end else begin
            rd_cnt <= (r_state == R_IDLE || rd_finish) ? '0 : rd_cnt + 1'b1;
            wr_cnt <= (w_state == W_IDLE || wr_finish) ? '0 : wr_cnt + 1'b1;
            if (rd_timeout || wr_timeout) wd_flag <= 1'b1;
        end
    end
`else
    // TO_CYC only matters when the watchdog is built in.
    logic unused_to_cyc;
    assign unused_to_cyc = (TO_CYC != 0);
    assign rd_timeout    = 1'b0;
    assign wr_timeout    = 1'b0;
    assign watchdog_err  = 1'b0;
`endif

endmodule
